// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive sweep checker: FSM state encoding
// and the width helper used to size the settle timer.
package sweep_pkg;

    // Sequencer states; the numeric values are what state_dbg reports.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } sweep_state_e;

    // Plain constants for the state register, mirroring the enum values.
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_APPLY = S_APPLY;
    localparam logic [2:0] ST_WAIT  = S_WAIT;
    localparam logic [2:0] ST_CHECK = S_CHECK;
    localparam logic [2:0] ST_DONE  = S_DONE;

    // Bits needed to hold SETTLE-1, never less than one bit.
    function automatic int settle_cnt_w(input int settle);
        return (settle <= 1) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Down-counter that times the DUT settle window. Loaded with SETTLE-1 on
// the edge that enters WAIT, so expired rises in the last WAIT cycle and
// WAIT lasts exactly SETTLE cycles.
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = settle_cnt_w(SETTLE);

    logic [CNT_W-1:0] cnt;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(SETTLE - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sweep_checker.sv
// Exhaustive self-test sequencer: walks every input vector of a
// combinational DUT, waits for it to settle, compares the response against
// a synchronous expected-value ROM and reports error count, first failing
// vector and a pass flag.
//
// Handshake: start is a level request seen only in IDLE; busy is high in
// every other state; done is a single-cycle pulse in the DONE state, and
// the results (err_count, fail_vec, fail_valid, pass, dut_in) are stable
// from the cycle after done until the next accepted start.
module sweep_checker
    import sweep_pkg::*;
#(
    parameter int IN_W         = 3,
    parameter int OUT_W        = 3,
    parameter int SETTLE       = 2,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  exp_addr,
    input  logic [OUT_W-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic [IN_W-1:0]  fail_vec,
    output logic             fail_valid,
    output logic [2:0]       state_dbg
);

    logic [2:0]      state;
    logic [IN_W-1:0] vec;
    logic            settle_expired;
    logic            mismatch;
    logic            last_vec;
    logic            sweep_end;
    logic            accept_start;

    // A start only counts in IDLE; in DONE or mid-sweep it is dropped.
    assign accept_start = (state == ST_IDLE) && start;

    // Full-width comparison of the settled DUT response against the ROM word.
    assign mismatch = (dut_out != exp_data);

    // The last vector ends the sweep, so vec never wraps back to zero.
    assign last_vec = (vec == {IN_W{1'b1}});

    // Sweep terminates after the last vector or, optionally, at the first error.
    assign sweep_end = last_vec || ((STOP_ON_FAIL != 0) && mismatch);

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ST_APPLY),
        .en      (state == ST_WAIT),
        .expired (settle_expired)
    );

    // Sequencer: IDLE -> APPLY -> WAIT (SETTLE cycles) -> CHECK -> APPLY | DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_APPLY;
                ST_APPLY: state <= ST_WAIT;
                ST_WAIT:  if (settle_expired) state <= ST_CHECK;
                ST_CHECK: state <= sweep_end ? ST_DONE : ST_APPLY;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Vector register: restarts at zero on start, advances after each non-final CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec <= '0;
        end else if (accept_start) begin
            vec <= '0;
        end else if ((state == ST_CHECK) && !sweep_end) begin
            vec <= vec + 1'b1;
        end
    end

    // Error bookkeeping: count every mismatch, latch only the first failing vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (accept_start) begin
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if ((state == ST_CHECK) && mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
            end
        end
    end

    // Verdict: cleared on start, decided in DONE from the final error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass <= 1'b0;
        end else if (accept_start) begin
            pass <= 1'b0;
        end else if (state == ST_DONE) begin
            pass <= (err_count == '0);
        end
    end

    // The vector register drives both the DUT and the ROM address, so the
    // ROM word lines up with the DUT response one cycle into WAIT.
    assign dut_in    = vec;
    assign exp_addr  = vec;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sweep_checker.sv
// Bench for sweep_checker: two instances (run to completion / stop at first
// error) share one clock. Each has an identity DUT and a bench-held ROM.
// The driver pushes a predicted result per sweep into exp_q; the monitor
// pops on every done pulse and compares, then checks the held results.
module tb_sweep_checker;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 3;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << IN_W;
    localparam int W      = 29;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic             start_w     [2];
    logic [IN_W-1:0]  dut_in_w    [2];
    logic [OUT_W-1:0] dut_out_w   [2];
    logic [IN_W-1:0]  exp_addr_w  [2];
    logic [OUT_W-1:0] exp_data_w  [2];
    logic             busy_w      [2];
    logic             done_w      [2];
    logic             pass_w      [2];
    logic [IN_W:0]    err_w       [2];
    logic [IN_W-1:0]  fail_vec_w  [2];
    logic             fail_val_w  [2];
    logic [2:0]       state_w     [2];

    logic [OUT_W-1:0] rom [2][NVEC];

    logic [W-1:0] exp_q[$];
    bit           mon_active = 1'b0;
    int           n_checks   = 0;
    int           n_errors   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs, identity combinational DUT and 1-cycle ROM ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sweep_checker #(
            .IN_W         (IN_W),
            .OUT_W        (OUT_W),
            .SETTLE       (SETTLE),
            .STOP_ON_FAIL (g)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_w[g]),
            .dut_in     (dut_in_w[g]),
            .dut_out    (dut_out_w[g]),
            .exp_addr   (exp_addr_w[g]),
            .exp_data   (exp_data_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .pass       (pass_w[g]),
            .err_count  (err_w[g]),
            .fail_vec   (fail_vec_w[g]),
            .fail_valid (fail_val_w[g]),
            .state_dbg  (state_w[g])
        );
    end

    always_comb begin
        for (int g = 0; g < 2; g++) dut_out_w[g] = OUT_W'(dut_in_w[g]);
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) exp_data_w[g] <= rom[g][exp_addr_w[g]];
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input int inst, input int done_edge, input int errs,
                                          input int fv, input bit fval, input bit ok, input int last);
        return {1'(inst), 16'(done_edge), 4'(errs), 3'(fv), fval, ok, 3'(last)};
    endfunction

    // Reference model: walk the vectors in order, identity DUT answers v.
    // A sweep that ends after vector `last` has its done pulse captured by
    // the edge (last+1)*(SETTLE+2)+1 edges after the start-sampling edge t0.
    function automatic logic [W-1:0] model(input int inst, input int t0);
        int errs  = 0;
        int fv    = 0;
        bit fval  = 1'b0;
        int last  = 0;
        for (int v = 0; v < NVEC; v++) begin
            last = v;
            if (rom[inst][v] != OUT_W'(v)) begin
                errs++;
                if (!fval) begin
                    fval = 1'b1;
                    fv   = v;
                end
                if (inst == 1) break;
            end
        end
        return pack(inst, t0 + (last + 1) * (SETTLE + 2) + 1, errs, fv, fval, errs == 0, last);
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done_w[i] === 1'b1) begin
                    mon_active = 1'b1;
                    chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("done_instance", 32'(i), 32'(e[28]));
                        chk("done_cycle", 32'((cyc + 1) % 65536), 32'(e[27:12]));
                        chk("err_count", 32'(err_w[i]), 32'(e[11:8]));
                        chk("fail_valid", 32'(fail_val_w[i]), 32'(e[4]));
                        if (e[4]) chk("fail_vec", 32'(fail_vec_w[i]), 32'(e[7:5]));
                        @(negedge clk);
                        chk("done_one_cycle", 32'(done_w[i]), 32'd0);
                        chk("busy_after_done", 32'(busy_w[i]), 32'd0);
                        chk("pass", 32'(pass_w[i]), 32'(e[3]));
                        chk("err_count_held", 32'(err_w[i]), 32'(e[11:8]));
                        chk("fail_valid_held", 32'(fail_val_w[i]), 32'(e[4]));
                        chk("dut_in_held", 32'(dut_in_w[i]), 32'(e[2:0]));
                        chk("exp_addr_held", 32'(exp_addr_w[i]), 32'(e[2:0]));
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // One sweep on instance `inst`; optionally a stray start pulse while busy.
    task automatic run_sweep(input int inst, input bit stray);
        int t0;
        int lat;
        logic [W-1:0] e;
        @(negedge clk);
        start_w[inst] = 1'b1;
        @(negedge clk);
        start_w[inst] = 1'b0;
        t0 = cyc;
        e  = model(inst, t0);
        exp_q.push_back(e);
        if (stray) begin
            lat = int'(e[27:12]) - t0;
            repeat ($urandom_range(1, lat - 2)) @(negedge clk);
            start_w[inst] = 1'b1;
            @(negedge clk);
            start_w[inst] = 1'b0;
        end
        wait_drain(100);
    endtask

    task automatic rom_identity();
        for (int g = 0; g < 2; g++)
            for (int v = 0; v < NVEC; v++) rom[g][v] = OUT_W'(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        rst        = 1'b1;
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        rom_identity();
        repeat (3) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy_w[i]), 32'd0);
            chk("rst_done", 32'(done_w[i]), 32'd0);
            chk("rst_pass", 32'(pass_w[i]), 32'd0);
            chk("rst_err", 32'(err_w[i]), 32'd0);
            chk("rst_fail_vec", 32'(fail_vec_w[i]), 32'd0);
            chk("rst_fail_valid", 32'(fail_val_w[i]), 32'd0);
            chk("rst_dut_in", 32'(dut_in_w[i]), 32'd0);
            chk("rst_exp_addr", 32'(exp_addr_w[i]), 32'd0);
        end
        rst = 1'b0;

        // Clean sweep: 33-cycle latency, pass.
        run_sweep(0, 1'b0);

        // Single corrupted word at vector 5.
        rom[0][5] = rom[0][5] ^ 3'b001;
        run_sweep(0, 1'b0);
        rom_identity();

        // Stop at first failure: vectors 2 and 6 bad, sweep ends at 2.
        rom[1][2] = ~rom[1][2];
        rom[1][6] = ~rom[1][6];
        run_sweep(1, 1'b0);

        // Every word wrong: count reaches 2^IN_W without overflow.
        for (int v = 0; v < NVEC; v++) rom[0][v] = ~OUT_W'(v);
        run_sweep(0, 1'b0);
        for (int v = 0; v < NVEC; v++) rom[1][v] = ~OUT_W'(v);
        run_sweep(1, 1'b0);
        rom_identity();

        // start held high: three back-to-back sweeps, one IDLE cycle apart.
        rom[0][3] = 3'b000;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        t0 = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back(model(0, t0 + k * 34));
        while (cyc < t0 + 78) @(negedge clk);
        start_w[0] = 1'b0;
        wait_drain(200);
        rom_identity();

        // Reset mid-sweep: outputs clear at once, no done, restart from vector 0.
        rom[0][0] = 3'b111;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_sweep_err", 32'(err_w[0]), 32'd1);
        chk("mid_sweep_busy", 32'(busy_w[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("async_rst_done", 32'(done_w[0]), 32'd0);
        chk("async_rst_pass", 32'(pass_w[0]), 32'd0);
        chk("async_rst_err", 32'(err_w[0]), 32'd0);
        chk("async_rst_fail_vec", 32'(fail_vec_w[0]), 32'd0);
        chk("async_rst_fail_valid", 32'(fail_val_w[0]), 32'd0);
        chk("async_rst_dut_in", 32'(dut_in_w[0]), 32'd0);
        chk("async_rst_exp_addr", 32'(exp_addr_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 1'b0);
        rom_identity();

        // Randomized ROM corruption on either instance, with stray starts.
        for (int it = 0; it < 12; it++) begin
            int inst;
            inst = $urandom_range(0, 1);
            for (int v = 0; v < NVEC; v++) begin
                if ($urandom_range(0, 3) == 0)
                    rom[inst][v] = OUT_W'(v) ^ OUT_W'($urandom_range(1, 7));
                else
                    rom[inst][v] = OUT_W'(v);
            end
            run_sweep(inst, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if something wedges the sequence.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
